// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets NREQ byte sources share one UART transmitter.
//   A winner's byte and parity select are latched, a one-cycle start strobe is
//   issued, the transmitter busy flag is followed through one frame, and an
//   idle gap is inserted before the next grant.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-low
//   req_valid    per-requester byte available (held until req_ready)
//   req_data     requester i byte at [8*i+7:8*i]
//   req_psel     per-requester parity select (0 even, 1 odd)
//   req_ready    one-hot, one-cycle accept pulse
//   tx_data      latched byte to the transmitter
//   tx_psel      latched parity select to the transmitter
//   tx_start     one-cycle frame start strobe
//   tx_busy      transmitter frame in progress
//   grant_id     index of current/last granted requester
//   active       high whenever the FSM is not idle
//   err_timeout  one-cycle pulse when tx_busy never rose after tx_start
module uart_tx_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [8*NREQ-1:0]       req_data,
    input  logic [NREQ-1:0]         req_psel,
    output logic [NREQ-1:0]         req_ready,
    output logic [7:0]              tx_data,
    output logic                    tx_psel,
    output logic                    tx_start,
    input  logic                    tx_busy,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    active,
    output logic                    err_timeout
);

    localparam int unsigned IDW  = $clog2(NREQ);
    localparam int unsigned CNTW = $clog2(TIMEOUT + 1);
    localparam int unsigned GAPW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StWaitBusy = 3'd2;
    localparam logic [2:0] StWaitDone = 3'd3;
    localparam logic [2:0] StGap      = 3'd4;

    // With no gap configured the frame end returns straight to idle.
    localparam logic [2:0] StAfterFrame = (GAP_CYCLES == 0) ? StIdle : StGap;

    logic [2:0]      state_q, state_d;
    logic [IDW-1:0]  ptr_q;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [GAPW-1:0] gap_q, gap_d;
    logic            timeout_hit;

    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic [IDW-1:0]  cand;
    logic [7:0]      win_data;
    logic            win_psel;

    // Winner: first valid index strictly after the last-grant pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDW'((32'(ptr_q) + i) % NREQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        win_psel = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win_idx) begin
                win_data = req_data[8*i +: 8];
                win_psel = req_psel[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gap_d       = gap_q;
        timeout_hit = 1'b0;
        case (state_q)
            StIdle: begin
                if (win_found) state_d = StStart;
            end
            StStart: begin
                cnt_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (cnt_q >= CNTW'(TIMEOUT - 1)) begin
                    // Counter stops here, so it can never wrap.
                    timeout_hit = 1'b1;
                    state_d     = StAfterFrame;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            StWaitDone: begin
                if (!tx_busy) state_d = StAfterFrame;
            end
            StGap: begin
                if (gap_q >= GAPW'(GAP_CYCLES - 1)) state_d = StIdle;
                else                                gap_d   = gap_q + GAPW'(1);
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StGap && state_q != StGap) gap_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            ptr_q       <= IDW'(NREQ - 1);
            cnt_q       <= '0;
            gap_q       <= '0;
            req_ready   <= '0;
            tx_data     <= '0;
            tx_psel     <= 1'b0;
            tx_start    <= 1'b0;
            grant_id    <= '0;
            active      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            active      <= (state_d != StIdle);
            err_timeout <= timeout_hit;
            tx_start    <= 1'b0;
            req_ready   <= '0;
            if (state_q == StIdle && win_found) begin
                // Strobes become visible in the START cycle that follows.
                tx_data   <= win_data;
                tx_psel   <= win_psel;
                grant_id  <= win_idx;
                ptr_q     <= win_idx;
                tx_start  <= 1'b1;
                req_ready <= NREQ'(1) << win_idx;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int GAP  = 2;
    localparam int TMO  = 1023;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [8*NREQ-1:0] req_data = '0;
    logic [NREQ-1:0]   req_psel = '0;
    logic [NREQ-1:0]   req_ready;
    logic [7:0]        tx_data;
    logic              tx_psel;
    logic              tx_start;
    logic              tx_busy = 1'b0;
    logic [1:0]        grant_id;
    logic              active;
    logic              err_timeout;

    uart_tx_arbiter #(
        .NREQ       (NREQ),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_psel    (req_psel),
        .req_ready   (req_ready),
        .tx_data     (tx_data),
        .tx_psel     (tx_psel),
        .tx_start    (tx_start),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .active      (active),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: pending bytes per requester and last-grant pointer.
    logic [7:0] dat [NREQ];
    logic       ps  [NREQ];
    int         ptr_m;
    int         exp_w;
    logic [7:0] exp_data;
    logic       exp_psel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_data[8*i +: 8] = dat[i];
            req_psel[i]        = ps[i];
        end
    endtask

    // Round-robin rule: nearest valid requester going forward from the pointer.
    function automatic int pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_start"},  32'(tx_start), 0);
        chk({tag, "_ready"},  32'(req_ready), 0);
        chk({tag, "_data"},   32'(tx_data), 0);
        chk({tag, "_psel"},   32'(tx_psel), 0);
        chk({tag, "_grant"},  32'(grant_id), 0);
        chk({tag, "_active"}, 32'(active), 0);
        chk({tag, "_err"},    32'(err_timeout), 0);
    endtask

    // Called in the cycle where a start strobe is due.
    task automatic check_start();
        exp_w = pick(req_valid, ptr_m);
        chk("tx_start",  32'(tx_start), 1);
        chk("req_ready", 32'(req_ready), 32'(1) << exp_w);
        chk("grant_id",  32'(grant_id), 32'(exp_w));
        chk("tx_data",   32'(tx_data), 32'(dat[exp_w]));
        chk("tx_psel",   32'(tx_psel), 32'(ps[exp_w]));
        chk("active",    32'(active), 1);
        chk("err_idle",  32'(err_timeout), 0);
        exp_data = dat[exp_w];
        exp_psel = ps[exp_w];
        ptr_m    = exp_w;
    endtask

    // Requester behaviour after an accept: the granted byte is consumed.
    task automatic after_grant();
        if ($urandom_range(1, 0) == 1) begin
            dat[exp_w] = 8'($urandom);
            ps[exp_w]  = 1'($urandom);
        end else begin
            req_valid[exp_w] = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && i != exp_w && $urandom_range(2, 0) == 0) begin
                req_valid[i] = 1'b1;
                dat[i]       = 8'($urandom);
                ps[i]        = 1'($urandom);
            end
        end
        if (req_valid == '0) begin
            int j;
            j            = int'($urandom_range(NREQ - 1, 0));
            req_valid[j] = 1'b1;
            dat[j]       = 8'($urandom);
            ps[j]        = 1'($urandom);
        end
        drive();
    endtask

    // Transmitter busy for cycles [d, d+l) after the start cycle; the gap follows.
    task automatic frame_body(input int d, input int l);
        for (int c = 1; c <= d + l + GAP + 1; c++) begin
            tick();
            tx_busy = (c >= d && c < d + l);
            chk("no_start",  32'(tx_start), 0);
            chk("no_ready",  32'(req_ready), 0);
            chk("hold_data", 32'(tx_data), 32'(exp_data));
            chk("hold_psel", 32'(tx_psel), 32'(exp_psel));
            chk("hold_gid",  32'(grant_id), 32'(exp_w));
            chk("frame_act", 32'(active), 32'(c < d + l + GAP + 1));
            chk("no_err",    32'(err_timeout), 0);
        end
        tx_busy = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            dat[i] = '0;
            ps[i]  = 1'b0;
        end
        drive();
        ptr_m = NREQ - 1;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        tick();

        // First grant: requester 0 with 0x55, strobe one cycle after valid.
        req_valid = 4'b0001;
        dat[0]    = 8'h55;
        ps[0]     = 1'b0;
        drive();
        tick();
        check_start();
        chk("first_data", 32'(tx_data), 32'h55);
        chk("first_ready", 32'(req_ready), 32'b0001);

        // Fairness: everyone valid continuously; requester 3 carries 0xA3/odd.
        req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            dat[i] = 8'($urandom);
            ps[i]  = 1'($urandom);
        end
        dat[3] = 8'hA3;
        ps[3]  = 1'b1;
        drive();
        frame_body(1, 19);
        for (int k = 0; k < 8; k++) begin
            tick();
            check_start();
            chk("fair_order", 32'(grant_id), 32'((k + 1) % NREQ));
            if ((k + 1) % NREQ == 3) begin
                chk("parity_psel", 32'(tx_psel), 1);
                chk("parity_data", 32'(tx_data), 32'hA3);
            end
            frame_body(1, 19);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 25; k++) begin
            tick();
            check_start();
            after_grant();
            frame_body(int'($urandom_range(5, 1)), int'($urandom_range(20, 1)));
        end

        // Timeout: busy never rises; only requester 2 pending afterwards.
        tick();
        check_start();
        req_valid = 4'b0100;
        dat[2]    = 8'($urandom);
        ps[2]     = 1'($urandom);
        drive();
        tx_busy = 1'b0;
        for (int c = 1; c <= TMO + GAP + 1; c++) begin
            tick();
            chk("tmo_err", 32'(err_timeout), 32'(c == TMO + 1));
            if (c >= TMO) begin
                chk("tmo_act",   32'(active), 32'(c < TMO + GAP + 1));
                chk("tmo_start", 32'(tx_start), 0);
            end
        end
        tick();
        check_start();
        chk("tmo_next_gid", 32'(grant_id), 2);

        // Abort in WAIT_DONE with requester 2 still valid.
        req_valid = 4'b1101;
        dat[0]    = 8'($urandom);
        ps[0]     = 1'($urandom);
        dat[3]    = 8'($urandom);
        ps[3]     = 1'($urandom);
        drive();
        for (int c = 1; c <= 6; c++) begin
            tick();
            tx_busy = 1'b1;
            chk("abort_pre_act", 32'(active), 1);
        end
        reset = 1'b0;
        #1;
        check_all_zero("abort");
        ptr_m   = NREQ - 1;
        tx_busy = 1'b0;
        tick();
        check_all_zero("abort_hold");
        reset = 1'b1;
        tick();
        check_start();
        chk("abort_first", 32'(grant_id), 0);

        for (int k = 0; k < 6; k++) begin
            after_grant();
            frame_body(int'($urandom_range(5, 1)), int'($urandom_range(20, 1)));
            tick();
            check_start();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
